logic_pipe_bist: RTL and testbench

Parametrised, registered successor to the flat gate-level logic test netlists: a WIDTH-bit datapath through STAGES identical mixed-logic stages, each followed by a flop rank. It serves as a clock-tree sink load for H-tree experiments. It has two modes: streaming with valid/ready backpressure, and a self-test mode in which an internal LFSR drives the pipe and a MISR compresses the outputs into a signature.

---
 rtl/logic_pipe_bist_if.sv | 36 +++
 rtl/logic_pipe_bist.sv | 186 ++++++++++++++++++
 tb/tb_logic_pipe_bist.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_pipe_bist_if.sv
// -----------------------------------------------------------------------------
// logic_pipe_bist_if
//   Streaming handshake bundle for logic_pipe_bist.
//   Upstream side : in_valid / in_ready / in_data
//   Downstream side: out_valid / out_ready / out_data
//   master : the environment (drives inputs, takes outputs)
//   slave  : the pipe itself
// -----------------------------------------------------------------------------
interface logic_pipe_bist_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/logic_pipe_bist.sv
// -----------------------------------------------------------------------------
// logic_pipe_bist
//   WIDTH-bit registered datapath of STAGES identical mixed-logic stages, used
//   as a clock-tree sink load. Two modes:
//     - streaming: valid/ready backpressure through bus (slave modport)
//     - self-test: an LFSR feeds the pipe, a MISR compresses the pipe output
//
// Ports
//   clk       : sole clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : streaming handshake (in_valid/in_ready/in_data,
//               out_valid/out_ready/out_data)
//   start     : one-cycle self-test request, honoured only in IDLE
//   busy      : self-test in progress (RUN or DRAIN)
//   done      : one-cycle pulse when the signature is final
//   signature : MISR value, held until the next start or rst
// -----------------------------------------------------------------------------
module logic_pipe_bist #(
  parameter int               WIDTH    = 8,
  parameter int               STAGES   = 4,
  parameter int               PATTERNS = 256,
  parameter logic [WIDTH-1:0] POLY     = 8'h1D,
  parameter logic [WIDTH-1:0] SEED     = 8'h01
) (
  input  logic                   clk,
  input  logic                   rst,
  logic_pipe_bist_if.slave       bus,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       signature
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x,
                                            input int               n);
    return (x << n) | (x >> (WIDTH - n));
  endfunction

  function automatic logic [WIDTH-1:0] stage_f(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
    r1 = rotl(x, 1);
    r2 = rotl(x, 2);
    return (x & r1) ^ ~(x | r2) ^ r1;
  endfunction

  // Galois shift shared by LFSR and MISR
  function automatic logic [WIDTH-1:0] galois_shift(input logic [WIDTH-1:0] v);
    return (v << 1) ^ (v[WIDTH-1] ? POLY : '0);
  endfunction

  function automatic logic [WIDTH-1:0] misr_step(input logic [WIDTH-1:0] s,
                                                 input logic [WIDTH-1:0] d);
    return galois_shift(s) ^ d;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_misr;
  logic [15:0]      r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [STAGES-1:0] r_vld_p;
  logic [WIDTH-1:0]  r_data_p [STAGES];

  logic             w_idle;
  logic             w_run;
  logic             w_out_valid;
  logic             w_stall;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_start_run;
  logic             w_stage0_v;
  logic [WIDTH-1:0] w_stage0_d;
  logic             w_absorb;

  assign w_idle      = (r_state == S_IDLE);
  assign w_run       = (r_state == S_RUN);
  // The pipe is only visible downstream while idle; self-test hides it so
  // out_ready can never stall an LFSR run.
  assign w_out_valid = r_vld_p[STAGES-1] & w_idle;
  assign w_stall     = w_out_valid & ~bus.out_ready;
  // rst gating keeps in_ready low during the reset cycle itself.
  assign w_in_ready  = ~rst & ~w_stall & w_idle;
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_start_run = w_idle & start;
  assign w_stage0_v  = w_run | w_accept;
  assign w_stage0_d  = w_run ? r_lfsr : bus.in_data;
  assign w_absorb    = (r_state == S_RUN || r_state == S_DRAIN) & r_vld_p[STAGES-1];

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = r_data_p[STAGES-1];
  assign busy          = r_busy;
  assign done          = r_done;
  assign signature     = r_misr;

  // ---------------------------------------------------------------------------
  // Pipeline ranks: stage 0 captures f(input), stage i captures f(stage i-1)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p <= '0;
      for (int i = 0; i < STAGES; i++) begin
        r_data_p[i] <= '0;
      end
    end else if (w_start_run) begin
      // Leftover streaming words must not reach the MISR.
      r_vld_p <= '0;
    end else if (!w_stall) begin
      r_vld_p[0]  <= w_stage0_v;
      r_data_p[0] <= stage_f(w_stage0_d);
      for (int i = 1; i < STAGES; i++) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_data_p[i] <= stage_f(r_data_p[i-1]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Self-test controller, LFSR, pattern counter, MISR
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_misr  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_absorb) begin
        r_misr <= misr_step(r_misr, r_data_p[STAGES-1]);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_RUN;
            r_lfsr  <= SEED;
            r_misr  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          r_lfsr <= galois_shift(r_lfsr);
          r_cnt  <= r_cnt + 16'd1;
          if (r_cnt == 16'(PATTERNS - 1)) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Final word is absorbed on the edge its valid leaves the last rank;
          // the all-clear is seen one edge later.
          if (~|r_vld_p) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_logic_pipe_bist.sv
module tb_logic_pipe_bist;
  localparam int W  = 8;
  localparam int S  = 4;
  localparam int S3 = 3;
  localparam int P  = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         start;
  logic         busy;
  logic         done;
  logic [W-1:0] signature;
  logic         start3;
  logic         busy3;
  logic         done3;
  logic [W-1:0] signature3;

  logic_pipe_bist_if #(.WIDTH(W)) bus ();
  logic_pipe_bist_if #(.WIDTH(W)) bus3 ();

  logic_pipe_bist #(
    .WIDTH(W), .STAGES(S), .PATTERNS(P), .POLY(8'h1D), .SEED(8'h01)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .start(start),
    .busy(busy), .done(done), .signature(signature)
  );

  logic_pipe_bist #(
    .WIDTH(W), .STAGES(S3), .PATTERNS(P), .POLY(8'h1D), .SEED(8'h01)
  ) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .start(start3),
    .busy(busy3), .done(done3), .signature(signature3)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q [$];
  logic [W-1:0] lfsr_ref [P] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                 8'h20, 8'h40, 8'h80, 8'h1D};

  // Bitwise reference of one stage: bit i of rotl(x,k) is x[i-k mod 8].
  function automatic logic [W-1:0] mf(input logic [W-1:0] x);
    logic [W-1:0] y;
    logic a, b, c;
    for (int i = 0; i < W; i++) begin
      a = x[i];
      b = x[(i + W - 1) % W];
      c = x[(i + W - 2) % W];
      y[i] = (a & b) ^ ~(a | c) ^ b;
    end
    return y;
  endfunction

  function automatic logic [W-1:0] mpipe(input logic [W-1:0] x, input int n);
    logic [W-1:0] y;
    y = x;
    for (int i = 0; i < n; i++) y = mf(y);
    return y;
  endfunction

  function automatic logic [W-1:0] mmisr(input logic [W-1:0] s, input logic [W-1:0] d);
    return {s[W-2:0], 1'b0} ^ (s[W-1] ? 8'h1D : 8'h00) ^ d;
  endfunction

  task test_reset();
    rst = 1'b1; start = 1'b0; start3 = 1'b0;
    bus.in_valid = 1'b1;  bus.in_data = 8'hA5;  bus.out_ready = 1'b1;
    bus3.in_valid = 1'b1; bus3.in_data = 8'h5A; bus3.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready_pre: got %b expected 0", bus.in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data: got %h expected 00", bus.out_data); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL rst_signature: got %h expected 00", signature); end
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0; bus3.in_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready_after: got %b expected 1", bus.in_ready); end
    for (int k = 0; k < S + 2; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus3.out_valid !== 1'b0) begin
        errors++; $display("FAIL rst_no_accept cycle %0d: got %b/%b expected 0/0", k, bus.out_valid, bus3.out_valid);
      end
    end
    @(posedge clk); #1;
  endtask

  task test_streaming();
    logic ev;
    logic [W-1:0] ed;
    bus.out_ready = 1'b1; bus3.out_ready = 1'b1;
    bus.in_valid = 1'b1;  bus.in_data = 8'h00;
    bus3.in_valid = 1'b1; bus3.in_data = 8'h00;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1 || bus3.in_ready !== 1'b1) begin errors++; $display("FAIL str_in_ready: got %b/%b expected 1/1", bus.in_ready, bus3.in_ready); end
    @(posedge clk); #1;
    bus.in_data = 8'hFF; bus3.in_data = 8'hFF;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus3.in_valid = 1'b0;
    for (int k = 1; k <= S + 2; k++) begin
      @(negedge clk);
      ev = (k == S - 1) || (k == S);
      ed = (k == S - 1) ? mpipe(8'h00, S) : mpipe(8'hFF, S);
      checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL str4_valid k=%0d: got %b expected %b", k, bus.out_valid, ev); end
      if (ev) begin
        checks++; if (bus.out_data !== ed) begin errors++; $display("FAIL str4_data k=%0d: got %h expected %h", k, bus.out_data, ed); end
      end
      ev = (k == S3 - 1) || (k == S3);
      ed = (k == S3 - 1) ? mpipe(8'h00, S3) : mpipe(8'hFF, S3);
      checks++; if (bus3.out_valid !== ev) begin errors++; $display("FAIL str3_valid k=%0d: got %b expected %b", k, bus3.out_valid, ev); end
      if (ev) begin
        checks++; if (bus3.out_data !== ed) begin errors++; $display("FAIL str3_data k=%0d: got %h expected %h", k, bus3.out_data, ed); end
      end
      @(posedge clk); #1;
    end
  endtask

  task test_backpressure();
    logic [W-1:0] words [20];
    logic [W-1:0] e;
    int sent, got, cyc;
    bit stalled;
    for (int i = 0; i < 20; i++) words[i] = W'($urandom);
    exp_q.delete();
    sent = 0; got = 0; stalled = 1'b0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_data = words[0];
    for (cyc = 0; cyc < 12 && !stalled; cyc++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(mpipe(bus.in_data, S));
        sent++;
        @(posedge clk); #1;
        bus.in_data = words[sent];
      end else begin
        stalled = 1'b1;
      end
    end
    checks++; if (!stalled || sent != S) begin errors++; $display("FAIL bp_fill: stalled=%0d accepted=%0d expected 1/%0d", stalled, sent, S); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_ctl k=%0d: got ready=%b valid=%b expected 0/1", k, bus.in_ready, bus.out_valid); end
      checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL bp_hold_data k=%0d: got %h expected %h", k, bus.out_data, exp_q[0]); end
    end
    cyc = 0;
    while (got < 20 && cyc < 300) begin
      @(posedge clk); #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_valid  = (sent < 20) && ($urandom_range(0, 3) != 0);
      bus.in_data   = words[(sent < 20) ? sent : 19];
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(mpipe(bus.in_data, S));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        checks++;
        got++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got word %h expected none", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.out_data !== e) begin errors++; $display("FAIL bp_data word %0d: got %h expected %h", got, bus.out_data, e); end
        end
      end
      cyc++;
    end
    checks++; if (got != 20 || exp_q.size() != 0) begin errors++; $display("FAIL bp_count: got %0d words left %0d expected 20/0", got, exp_q.size()); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int k = 0; k < S + 1; k++) begin
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup k=%0d: got %b expected 0", k, bus.out_valid); end
      @(posedge clk); #1;
    end
  endtask

  // mode 0: clean run; 1: extra start pulses in RUN and DONE; 2: streaming
  // words in flight when start arrives
  task test_selftest(input int mode);
    logic [W-1:0] sig_ref, ex;
    sig_ref = 8'h00;
    for (int k = 0; k < P; k++) sig_ref = mmisr(sig_ref, mpipe(lfsr_ref[k], S));
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    if (mode == 2) begin
      bus.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        bus.in_data = W'($urandom);
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b0;
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.out_ready = 1'b0;
    for (int n = 0; n <= P + S + 4; n++) begin
      @(negedge clk);
      checks++; if (busy !== (n < P + S + 1)) begin errors++; $display("FAIL bist%0d_busy n=%0d: got %b expected %b", mode, n, busy, (n < P + S + 1)); end
      checks++; if (done !== (n == P + S + 1)) begin errors++; $display("FAIL bist%0d_done n=%0d: got %b expected %b", mode, n, done, (n == P + S + 1)); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bist%0d_out_valid n=%0d: got %b expected 0", mode, n, bus.out_valid); end
      if (n <= P + S + 1) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bist%0d_in_ready n=%0d: got %b expected 0", mode, n, bus.in_ready); end
      end
      if (n >= S && n <= P + S - 1) begin
        ex = mpipe(lfsr_ref[n - S], S);
        checks++; if (bus.out_data !== ex) begin errors++; $display("FAIL bist%0d_pipe n=%0d: got %h expected %h", mode, n, bus.out_data, ex); end
      end
      if (n >= P + S + 1) begin
        checks++; if (signature !== sig_ref) begin errors++; $display("FAIL bist%0d_signature n=%0d: got %h expected %h", mode, n, signature, sig_ref); end
      end
      @(posedge clk); #1;
      start = (mode == 1) && (n == 2 || n == P + S);
      bus.in_valid = (n < P);
    end
    start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
  endtask

  task test_rst_abort();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (P + 2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_ctl: got busy=%b done=%b expected 0/0", busy, done); end
    checks++; if (signature !== 8'h00) begin errors++; $display("FAIL abort_signature: got %h expected 00", signature); end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_quiet k=%0d: got busy=%b done=%b expected 0/0", k, busy, done); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_selftest(0);
    test_selftest(1);
    test_rst_abort();
    test_selftest(0);
    test_selftest(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
